// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame receiver and its downstream decode.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } spi_state_e;

   // Bit counter must be able to hold FRAME_BITS itself, not just FRAME_BITS-1.
   function automatic int spi_cnt_w(input int frame_bits);
      return $clog2(frame_bits + 1);
   endfunction

   // Coordinate/colour field widths of the 128-bit frame as unpacked downstream.
   localparam int SPI_X_W     = 16;
   localparam int SPI_Y_W     = 16;
   localparam int SPI_Z_W     = 16;
   localparam int SPI_RGBA_W  = 32;
   localparam int SPI_FLAGS_W = 48;

endpackage

// File: rtl/spi_frame_rx_sync.sv
// Multi-flop synchroniser for one asynchronous input plus rise/fall strobes in the clk domain.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0,
   parameter logic INVERT      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL ^ INVERT;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= o_level;
      end
   end

   // Inversion sits after the synchroniser so edges are always in the idle-low sense.
   assign o_level = r_sync[SYNC_STAGES-1] ^ INVERT;
   assign o_rise  = o_level & ~r_prev;
   assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: oversampled sck/cs_n/sdi, valid/ready output, overrun/short-frame flags.
module spi_frame_rx
   import spi_pkg::*;
#(
   parameter int   FRAME_BITS  = 128,
   parameter int   SYNC_STAGES = 2,
   parameter logic CPOL        = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  cs_n,
   output logic                  sdo,
   input  logic [FRAME_BITS-1:0] tx_word,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int             CW       = spi_cnt_w(FRAME_BITS);
   localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME_BITS - 1);

   logic w_sck_level_unused, w_sck_rise, w_sck_fall;
   logic w_cs_level, w_cs_rise, w_cs_fall;
   logic w_sdi, w_sdi_rise_unused, w_sdi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL), .INVERT(CPOL)) u_sync_sck (
      .clk(clk), .rst_n(rst_n), .i_async(sck),
      .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1), .INVERT(1'b0)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .i_async(cs_n),
      .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .INVERT(1'b0)) u_sync_sdi (
      .clk(clk), .rst_n(rst_n), .i_async(sdi),
      .o_level(w_sdi), .o_rise(w_sdi_rise_unused), .o_fall(w_sdi_fall_unused)
   );

   spi_state_e            r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [FRAME_BITS-1:0] r_rx_sr, r_tx_sr, r_frame_data;
   logic                  r_frame_valid, r_frame_err, r_overrun;

   logic                  w_start, w_abort, w_leave, w_shift_in, w_shift_out, w_commit;
   logic [FRAME_BITS-1:0] w_rx_nxt;

   assign w_rx_nxt = {r_rx_sr[FRAME_BITS-2:0], w_sdi};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_leave     = 1'b0;
      w_shift_in  = 1'b0;
      w_shift_out = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            // cs_n release wins over a coincident sck edge; a zero-bit frame is not an error.
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_leave     = 1'b1;
               w_abort     = (r_cnt != '0);
            end else begin
               if (w_sck_rise) begin
                  w_shift_in = 1'b1;
                  if (r_cnt == LAST_CNT) begin
                     w_commit    = 1'b1;
                     w_state_nxt = ST_DONE;
                  end
               end
               if (w_sck_fall) w_shift_out = 1'b1;
            end
         end
         ST_DONE: begin
            if (w_cs_rise) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_rx_sr       <= '0;
         r_tx_sr       <= '0;
         r_frame_data  <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_frame_err <= w_abort;
         r_overrun   <= 1'b0;
         if (w_start) begin
            r_cnt   <= '0;
            r_rx_sr <= '0;
            r_tx_sr <= tx_word;
         end
         if (w_shift_in) begin
            r_rx_sr <= w_rx_nxt;
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_shift_out) r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
         if (w_leave) begin
            r_cnt   <= '0;
            r_rx_sr <= '0;
            r_tx_sr <= '0;
         end
         // A commit landing in the same cycle as a handshake replaces the consumed frame.
         if (w_commit) begin
            if (!r_frame_valid || frame_ready) begin
               r_frame_data  <= w_rx_nxt;
               r_frame_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_frame_valid && frame_ready) begin
            r_frame_valid <= 1'b0;
         end
      end
   end

   assign sdo         = (!w_cs_level && r_state != ST_DONE) ? r_tx_sr[FRAME_BITS-1] : 1'b0;
   assign frame_data  = r_frame_data;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench: a CPOL=0 and a CPOL=1 receiver share cs_n/sdi, the second sees inverted sck.
module tb_spi_frame_rx;

   localparam int FB = 16;
   localparam logic [1:0] EV_ACC = 2'd0;
   localparam logic [1:0] EV_OVR = 2'd1;
   localparam logic [1:0] EV_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [FB-1:0] data;
   } ev_t;

   logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, sdi = 1'b0, cs_n = 1'b1, frame_ready = 1'b0;
   logic [FB-1:0] tx_word = '0;
   logic sck1;
   logic sdo0, fv0, fe0, ov0, sdo1, fv1, fe1, ov1;
   logic [FB-1:0] fd0, fd1;

   int n_cmp = 0;
   int n_bad = 0;
   ev_t q0[$];
   ev_t q1[$];
   logic [31:0] so0, so1;

   assign sck1 = ~sck;

   always #5 clk = ~clk;

   spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2), .CPOL(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .cs_n(cs_n), .sdo(sdo0),
      .tx_word(tx_word), .frame_data(fd0), .frame_valid(fv0), .frame_ready(frame_ready),
      .frame_err(fe0), .overrun(ov0)
   );

   spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2), .CPOL(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sck(sck1), .sdi(sdi), .cs_n(cs_n), .sdo(sdo1),
      .tx_word(tx_word), .frame_data(fd1), .frame_valid(fv1), .frame_ready(frame_ready),
      .frame_err(fe1), .overrun(ov1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [FB-1:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      q0.push_back(e);
      q1.push_back(e);
   endtask

   task automatic pop_chk(input int d, input logic [1:0] k, input logic [FB-1:0] data);
      ev_t x;
      int  sz;
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL dut%0d unexpected event: got kind %0d data %h, required none", d, k, data);
      end else begin
         if (d == 0) x = q0.pop_front();
         else        x = q1.pop_front();
         chk($sformatf("dut%0d event", d), {14'd0, k, data}, {14'd0, x.kind, x.data});
      end
   endtask

   task automatic mon(input int d, input logic v, input logic [FB-1:0] data,
                      input logic e, input logic o);
      if (v && frame_ready) pop_chk(d, EV_ACC, data);
      if (o)                pop_chk(d, EV_OVR, '0);
      if (e)                pop_chk(d, EV_ERR, '0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, fv0, fd0, fe0, ov0);
         mon(1, fv1, fd1, fe1, ov1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mode 0 master: sdi changes with sck low, sdo is sampled just as sck rises.
   task automatic send_bits(input logic [31:0] w, input int n, input bit rdy_pulse,
                            output logic [31:0] s0, output logic [31:0] s1);
      s0 = '0;
      s1 = '0;
      for (int i = 0; i < n; i++) begin
         sdi = w[n-1-i];
         tick(4);
         s0  = {s0[30:0], sdo0};
         s1  = {s1[30:0], sdo1};
         sck = 1'b1;
         if (rdy_pulse && i == n - 1) begin
            tick(2);
            frame_ready = 1'b1;
            tick(1);
            frame_ready = 1'b0;
            tick(1);
         end else begin
            tick(4);
         end
         sck = 1'b0;
      end
   endtask

   task automatic do_frame(input logic [FB-1:0] w, input bit rdy_pulse);
      cs_n = 1'b0;
      send_bits({16'd0, w}, FB, rdy_pulse, so0, so1);
      tick(4);
      cs_n = 1'b1;
      sdi  = 1'b0;
      tick(6);
   endtask

   initial begin
      #1;
      chk("reset valid0", {31'd0, fv0}, 32'd0);
      chk("reset data0", {16'd0, fd0}, 32'd0);
      chk("reset pulses1", {29'd0, fe1, ov1, sdo1}, 32'd0);
      tick(3);
      rst_n = 1'b1;
      tick(4);

      // basic frame with full-duplex response
      tx_word = 16'hA5C3;
      frame_ready = 1'b1;
      push(EV_ACC, 16'h1234);
      do_frame(16'h1234, 1'b0);
      chk("sdo word dut0", so0, 32'h0000A5C3);
      chk("sdo word dut1", so1, 32'h0000A5C3);
      chk("sdo idle", {30'd0, sdo0, sdo1}, 32'd0);
      tx_word = '0;

      // backpressure: second frame dropped, first held
      frame_ready = 1'b0;
      push(EV_OVR, '0);
      push(EV_ACC, 16'h1111);
      do_frame(16'h1111, 1'b0);
      do_frame(16'h2222, 1'b0);
      chk("held data0", {16'd0, fd0}, 32'h1111);
      chk("held data1", {16'd0, fd1}, 32'h1111);
      chk("held valid", {30'd0, fv0, fv1}, 32'd3);
      frame_ready = 1'b1;
      tick(4);
      frame_ready = 1'b0;

      // accept and commit coincide: no overrun, new frame kept
      push(EV_ACC, 16'h1111);
      push(EV_ACC, 16'h2222);
      do_frame(16'h1111, 1'b0);
      do_frame(16'h2222, 1'b1);
      chk("swap data0", {16'd0, fd0}, 32'h2222);
      chk("swap valid", {30'd0, fv0, fv1}, 32'd3);
      frame_ready = 1'b1;
      tick(3);

      // short frame of 9 bits, then a good one
      push(EV_ERR, '0);
      cs_n = 1'b0;
      send_bits(32'h000001AB, 9, 1'b0, so0, so1);
      tick(4);
      cs_n = 1'b1;
      sdi  = 1'b0;
      tick(6);
      chk("short valid", {30'd0, fv0, fv1}, 32'd0);
      push(EV_ACC, 16'hBEEF);
      do_frame(16'hBEEF, 1'b0);

      // 20 sck pulses in one window: only the first 16 count
      push(EV_ACC, 16'h5A5A);
      cs_n = 1'b0;
      send_bits(32'h0005A5AF, 20, 1'b0, so0, so1);
      tick(4);
      cs_n = 1'b1;
      sdi  = 1'b0;
      tick(6);

      // async reset mid-frame with a pending frame
      frame_ready = 1'b0;
      do_frame(16'h7777, 1'b0);
      chk("pending data", {16'd0, fd0}, 32'h7777);
      tx_word = 16'hFFFF;
      cs_n = 1'b0;
      send_bits(32'h00000015, 5, 1'b0, so0, so1);
      chk("pre-reset sdo", {30'd0, sdo0, sdo1}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst dut0", {fd0, 12'd0, fv0, fe0, ov0, sdo0}, 32'd0);
      chk("async rst dut1", {fd1, 12'd0, fv1, fe1, ov1, sdo1}, 32'd0);
      cs_n = 1'b1;
      sck  = 1'b0;
      sdi  = 1'b0;
      tx_word = '0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      frame_ready = 1'b1;
      push(EV_ACC, 16'h0F0F);
      do_frame(16'h0F0F, 1'b0);

      // idle-high sck on the CPOL=1 instance
      push(EV_ACC, 16'h8001);
      do_frame(16'h8001, 1'b0);

      tick(10);
      chk("left in q0", q0.size(), 32'd0);
      chk("left in q1", q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
